// File: rtl/tile_cfg_pkg.sv
// Shared types and sizing helpers for the tile configuration bank loader.
package tile_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_DONE
  } state_t;

  // Number of WORD_W-bit segments covering the tile.
  function automatic int unsigned num_seg(input int unsigned nb, input int unsigned ww);
    return nb / ww;
  endfunction

  // Width of a segment index; never narrower than one bit.
  function automatic int unsigned seg_w(input int unsigned ns);
    return (ns > 1) ? $clog2(ns) : 1;
  endfunction

endpackage

// File: rtl/cfg_pulse_timer.sv
// Loadable down-counter that times the word-line pulse of one segment.
module cfg_pulse_timer
  import tile_cfg_pkg::*;
#(
  parameter int unsigned PULSE = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic tc_c
);

  localparam int unsigned CNT_W = (PULSE > 1) ? $clog2(PULSE) : 1;

  logic [CNT_W-1:0] count;

  // Load with PULSE-1 so terminal count lands on the last pulse cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(PULSE - 1);
    end else if (run && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign tc_c = (count == '0);

endmodule

// File: rtl/tile_cfg_bank_loader.sv
// Streams configuration words into a tile's flattened bl/wl memory-bank buses.
module tile_cfg_bank_loader
  import tile_cfg_pkg::*;
#(
  parameter int unsigned NUM_BITS = 1260,
  parameter int unsigned WORD_W   = 20,
  parameter int unsigned WL_PULSE = 2,
  localparam int unsigned SEG_W   = seg_w(num_seg(NUM_BITS, WORD_W))
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WORD_W-1:0]   cfg_data,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic [0:NUM_BITS-1] bl,
  output logic [0:NUM_BITS-1] wl,
  output logic                busy,
  output logic                done,
  output logic [SEG_W-1:0]    seg_idx
);

  localparam int unsigned NUM_SEG = num_seg(NUM_BITS, WORD_W);
  localparam int unsigned IDX_W   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  if ((NUM_BITS % WORD_W) != 0) begin : g_bad_word_w
    $error("NUM_BITS must be a whole multiple of WORD_W");
  end
  if (WL_PULSE < 1) begin : g_bad_pulse
    $error("WL_PULSE must be at least 1");
  end

  typedef logic [0:NUM_BITS-1] cells_t;

  state_t state;
  logic   timer_load_c;
  logic   timer_run_c;
  logic   timer_tc_c;

  // Place a word onto its segment's cells: word bit i lands on cell seg*WORD_W+i.
  function automatic cells_t seg_cells(input logic [WORD_W-1:0] word,
                                       input logic [SEG_W-1:0]  seg);
    cells_t            r;
    logic [WORD_W-1:0] w;
    logic [IDX_W-1:0]  idx;
    r   = '0;
    w   = word;
    idx = IDX_W'(32'(seg) * WORD_W);
    for (int unsigned i = 0; i < WORD_W; i++) begin
      r[idx] = w[0];
      w      = w >> 1;
      idx    = idx + IDX_W'(1);
    end
    return r;
  endfunction

  assign timer_load_c = (state == ST_SETUP);
  assign timer_run_c  = (state == ST_PULSE);

  cfg_pulse_timer #(
    .PULSE (WL_PULSE)
  ) u_pulse_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load_c),
    .run   (timer_run_c),
    .tc_c  (timer_tc_c)
  );

  // Load sequencer; the bl register doubles as the latched word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      bl        <= '0;
      wl        <= '0;
      cfg_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      seg_idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_WAIT;
            seg_idx   <= '0;
            cfg_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cfg_valid && cfg_ready) begin
            state     <= ST_SETUP;
            cfg_ready <= 1'b0;
            bl        <= seg_cells(cfg_data, seg_idx);
          end
        end
        ST_SETUP: begin
          state <= ST_PULSE;
          wl    <= seg_cells('1, seg_idx);
        end
        ST_PULSE: begin
          if (timer_tc_c) begin
            state <= ST_HOLD;
            wl    <= '0;
          end
        end
        ST_HOLD: begin
          bl <= '0;
          if (seg_idx == SEG_W'(NUM_SEG - 1)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state     <= ST_WAIT;
            seg_idx   <= seg_idx + SEG_W'(1);
            cfg_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          if (start) begin
            state     <= ST_WAIT;
            seg_idx   <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
            cfg_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          bl        <= '0;
          wl        <= '0;
          cfg_ready <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
